// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and the default data width.
// The decoder/control unit imports the same codes so both sides agree.
package alu_pkg;

  // Default operand/result width of the execute-stage ALU.
  localparam int DEFAULT_WIDTH = 32;

  // Operation select type and the eight ALUControl encodings.
  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 3'b000;
  localparam alu_op_t ALU_SUB = 3'b001;
  localparam alu_op_t ALU_AND = 3'b010;
  localparam alu_op_t ALU_OR  = 3'b011;
  localparam alu_op_t ALU_XOR = 3'b100;
  localparam alu_op_t ALU_SLT = 3'b101;
  localparam alu_op_t ALU_SLL = 3'b110;
  localparam alu_op_t ALU_SRL = 3'b111;

endpackage : alu_pkg

// File: rtl/alu_if.sv
// Operand/result bundle between the execute stage and the ALU.
// The master side (pipeline) drives operands and the valid strobe;
// the slave side (the ALU) returns the registered result and flags.
interface alu_if #(
  parameter int WIDTH = alu_pkg::DEFAULT_WIDTH
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       ALUControl;
  logic             in_valid;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             out_valid;

  modport master (
    output A,
    output B,
    output ALUControl,
    output in_valid,
    input  Result,
    input  Zero,
    input  out_valid
  );

  modport slave (
    input  A,
    input  B,
    input  ALUControl,
    input  in_valid,
    output Result,
    output Zero,
    output out_valid
  );

endinterface : alu_if

// File: rtl/alu_datapath.sv
// Purely combinational ALU datapath: one shared add/subtract, logic ops,
// true signed compare for SLT, barrel shifts, and the Zero NOR.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  // Only the low log2(WIDTH) bits of B select the shift distance.
  localparam int SHW = $clog2(WIDTH);

  logic             is_sub;
  logic [WIDTH-1:0] b_opnd;
  logic [WIDTH-1:0] carry_in;
  logic [WIDTH-1:0] sum;
  logic             lt_signed;
  logic [SHW-1:0]   shamt;

  // Single adder serves ADD and SUB (A + ~B + 1); carry/overflow discarded.
  always_comb begin
    is_sub   = (op == ALU_SUB);
    b_opnd   = is_sub ? ~b : b;
    carry_in = {{(WIDTH-1){1'b0}}, is_sub};
    sum      = a + b_opnd + carry_in;
  end

  // SLT uses a real signed comparison so subtraction overflow cannot flip it.
  always_comb begin
    lt_signed = ($signed(a) < $signed(b));
    shamt     = b[SHW-1:0];
  end

  // Operation select; upper bits of B are ignored for shifts.
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = sum;
      ALU_SUB: result = sum;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt_signed};
      ALU_SLL: result = a << shamt;
      ALU_SRL: result = a >> shamt;
      default: result = '0;
    endcase
  end

  // Zero is derived from the very result that gets registered.
  always_comb begin
    zero = ~|result;
  end

endmodule : alu_datapath

// File: rtl/alu.sv
// Execute-stage ALU top: combinational datapath followed by one output
// register stage holding Result, Zero and out_valid.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  logic [WIDTH-1:0] dp_result;
  logic             dp_zero;

  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d,   zero_q;
  logic             out_valid_d, out_valid_q;

  alu_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .a      (bus.A),
    .b      (bus.B),
    .op     (bus.ALUControl),
    .result (dp_result),
    .zero   (dp_zero)
  );

  // Load a new result only on valid input; otherwise hold and drop out_valid.
  always_comb begin
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    if (bus.in_valid) begin
      result_d    = dp_result;
      zero_d      = dp_zero;
      out_valid_d = 1'b1;
    end
  end

  // Output register; reset wins over a same-cycle valid operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.Result    = result_q;
  assign bus.Zero      = zero_q;
  assign bus.out_valid = out_valid_q;

endmodule : alu

// File: tb/tb_alu.sv
// Directed-vector bench for the execute-stage ALU.
module tb_alu;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  alu_if #(.WIDTH(32)) bus ();

  alu #(.WIDTH(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one input set, let one rising edge sample it, settle 1ns after.
  task automatic issue(input logic v, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    bus.in_valid   = v;
    bus.ALUControl = op;
    bus.A          = a;
    bus.B          = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    issue(1'b1, ALU_ADD, 32'd1, 32'd2);
    issue(1'b1, ALU_ADD, 32'd1, 32'd2);
    n_vec++;
    if (bus.Result !== 32'h0) begin
      $display("FAIL reset_result: got %h want %h", bus.Result, 32'h0); n_miss++;
    end
    n_vec++;
    if (bus.Zero !== 1'b1) begin
      $display("FAIL reset_zero: got %b want 1", bus.Zero); n_miss++;
    end
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); n_miss++;
    end
    rst_n = 1'b1;
  endtask

  // Table-driven single-operation checks covering all eight opcodes.
  task automatic test_ops();
    logic [2:0]  top [14];
    logic [31:0] ta  [14];
    logic [31:0] tb  [14];
    logic [31:0] tr  [14];
    logic        exp_zero;
    top = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
            ALU_SLT, ALU_SLT, ALU_SLT, ALU_SLT, ALU_SLT,
            ALU_SLL, ALU_SRL, ALU_SRL, ALU_SLL};
    ta  = '{32'd10, 32'd15, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000,
            32'd10, 32'hFFFFFFFF, 32'd1, 32'h80000000, 32'h7FFFFFFF,
            32'h00000001, 32'h80000000, 32'hF0000000, 32'h0000000F};
    tb  = '{32'd20, 32'd15, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF,
            32'd20, 32'd1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000,
            32'h00000024, 32'd31, 32'hFFFFFFE0, 32'h0000003C};
    tr  = '{32'h0000001E, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'd1, 32'd1, 32'd0, 32'd1, 32'd0,
            32'h00000010, 32'h00000001, 32'hF0000000, 32'hF0000000};
    for (int i = 0; i < 14; i++) begin
      issue(1'b1, top[i], ta[i], tb[i]);
      exp_zero = (tr[i] == 32'h0);
      n_vec++;
      if (bus.Result !== tr[i]) begin
        $display("FAIL op%0d_result (op=%b A=%h B=%h): got %h want %h",
                 i, top[i], ta[i], tb[i], bus.Result, tr[i]);
        n_miss++;
      end
      n_vec++;
      if (bus.Zero !== exp_zero) begin
        $display("FAIL op%0d_zero: got %b want %b", i, bus.Zero, exp_zero); n_miss++;
      end
      n_vec++;
      if (bus.out_valid !== 1'b1) begin
        $display("FAIL op%0d_out_valid: got %b want 1", i, bus.out_valid); n_miss++;
      end
      $display("vector %0d op=%b A=%h B=%h -> Result=%h Zero=%b", i, top[i],
               ta[i], tb[i], bus.Result, bus.Zero);
    end
  endtask

  // A valid ADD followed by two idle cycles with different operands.
  task automatic test_valid_hold();
    logic        tv [3];
    logic [2:0]  top[3];
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    tv  = '{1'b1, 1'b0, 1'b0};
    top = '{ALU_ADD, ALU_ADD, ALU_SUB};
    ta  = '{32'd1, 32'd7, 32'd3};
    tb  = '{32'd1, 32'd9, 32'd3};
    for (int i = 0; i < 3; i++) begin
      issue(tv[i], top[i], ta[i], tb[i]);
      n_vec++;
      if (bus.Result !== 32'd2) begin
        $display("FAIL hold%0d_result: got %h want %h", i, bus.Result, 32'd2); n_miss++;
      end
      n_vec++;
      if (bus.Zero !== 1'b0) begin
        $display("FAIL hold%0d_zero: got %b want 0", i, bus.Zero); n_miss++;
      end
      n_vec++;
      if (bus.out_valid !== tv[i]) begin
        $display("FAIL hold%0d_out_valid: got %b want %b", i, bus.out_valid, tv[i]);
        n_miss++;
      end
      $display("hold cycle %0d in_valid=%b -> Result=%h out_valid=%b", i, tv[i],
               bus.Result, bus.out_valid);
    end
  endtask

  // Consecutive valid operations, including wrap-around cases.
  task automatic test_back_to_back();
    logic [2:0]  top[4];
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    logic [31:0] tr [4];
    top = '{ALU_SUB, ALU_ADD, ALU_SLL, ALU_SRL};
    ta  = '{32'd0, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF};
    tb  = '{32'd1, 32'd1, 32'h0000001F, 32'd5};
    tr  = '{32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h07FFFFFF};
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, top[i], ta[i], tb[i]);
      n_vec++;
      if (bus.Result !== tr[i] || bus.Zero !== (tr[i] == 32'h0) ||
          bus.out_valid !== 1'b1) begin
        $display("FAIL b2b%0d: got Result=%h Zero=%b out_valid=%b want %h %b 1",
                 i, bus.Result, bus.Zero, bus.out_valid, tr[i], (tr[i] == 32'h0));
        n_miss++;
      end
      $display("b2b %0d op=%b -> Result=%h", i, top[i], bus.Result);
    end
  endtask

  // Reset with a colliding valid ADD, then the first post-reset operation.
  task automatic test_reset_priority();
    issue(1'b1, ALU_ADD, 32'd10, 32'd20);
    n_vec++;
    if (bus.Result !== 32'h1E) begin
      $display("FAIL rstp_pre: got %h want %h", bus.Result, 32'h1E); n_miss++;
    end
    rst_n = 1'b0;
    issue(1'b1, ALU_ADD, 32'd5, 32'd5);
    n_vec++;
    if (bus.Result !== 32'h0 || bus.Zero !== 1'b1 || bus.out_valid !== 1'b0) begin
      $display("FAIL rstp_reset: got Result=%h Zero=%b out_valid=%b want 0 1 0",
               bus.Result, bus.Zero, bus.out_valid);
      n_miss++;
    end
    rst_n = 1'b1;
    issue(1'b1, ALU_ADD, 32'd5, 32'd5);
    n_vec++;
    if (bus.Result !== 32'd10 || bus.Zero !== 1'b0 || bus.out_valid !== 1'b1) begin
      $display("FAIL rstp_after: got Result=%h Zero=%b out_valid=%b want %h 0 1",
               bus.Result, bus.Zero, bus.out_valid, 32'd10);
      n_miss++;
    end
    $display("reset priority: after release Result=%h out_valid=%b",
             bus.Result, bus.out_valid);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    bus.in_valid   = 1'b0;
    bus.ALUControl = ALU_ADD;
    bus.A          = '0;
    bus.B          = '0;
    test_reset();
    test_ops();
    test_valid_hold();
    test_back_to_back();
    test_reset_priority();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_alu

// File: doc/alu.md
# alu

Integer ALU for the execute stage of the 5-stage pipelined RISC-V core. It performs one of eight 32-bit operations on operands A and B, selected by a 3-bit ALUControl code. Result and a Zero flag are registered once, so they are visible one cycle after the operands are sampled. The Zero flag feeds branch resolution, and Result feeds the EX/MEM pipeline path.

## Interface
- WIDTH, default 32: operand and result width. Only 32 is required.
- clk, input, 1: single clock. All state updates on the rising edge.
- rst_n, input, 1: reset. Synchronous and active-low.
- A, input, WIDTH: operand A, treated as two's complement for SLT.
- B, input, WIDTH: operand B. Bits [4:0] give the shift amount for shift operations.
- ALUControl, input, 3: operation select.
- in_valid, input, 1: operands are valid this cycle.
- Result, output, WIDTH: registered operation result.
- Zero, output, 1: registered flag. It is 1 exactly when Result == 0.
- out_valid, output, 1: Result and Zero hold a new value this cycle.

## Operation
- ALUControl codes:
  - 000 ADD: A+B, modulo 2^32.
  - 001 SUB: A−B, modulo 2^32.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLT: signed compare, {31'b0, $signed(A)<$signed(B)}.
  - 110 SLL: A << B[4:0].
  - 111 SRL: logical A >> B[4:0].
- SLT must use a true signed compare, not the sign bit of A−B:
  - A=32'hFFFFFFFF, B=1 gives 1.
  - A=32'h80000000, B=32'h7FFFFFFF gives 1, even though the subtraction overflows.
- ADD and SUB carry-out and overflow are discarded. No flags other than Zero exist.
- SLL and SRL ignore B[31:5]. A shift amount of 0 returns A unchanged.
- Zero is computed from the next-state Result and registered alongside it, so Zero and Result never disagree.
- When in_valid is 0:
  - Result and Zero hold their previous values.
  - out_valid is 0 on the next cycle.
- When in_valid is 1:
  - Result and Zero load the new values.
  - out_valid is 1 on the next cycle.

## Timing
- Latency: operands sampled at rising edge N appear on Result/Zero/out_valid after edge N.
- Throughput: one operation per cycle. Back-to-back valid inputs each produce a valid output on consecutive cycles.
- Reset values, applied at any rising edge where rst_n is 0:
  - Result = 0.
  - Zero = 1, consistent with Result = 0.
  - out_valid = 0.
- Reset has priority over in_valid. An operation sampled in the same cycle as reset is dropped and produces no out_valid.
- The first rising edge with rst_n = 1 samples inputs normally.
- ALUControl and the operands only need to be stable at the rising edge. There is no internal multi-cycle state.
- The combinational path is one add/subtract, a 32-bit compare, a barrel shift, a 32-bit mux and a 32-input NOR for Zero. It must close at the pipeline clock with no multicycle constraint.

## Structure
- Shared package alu_pkg holds:
  - localparams for the eight ALUControl codes: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL.
  - the default WIDTH.
- The decoder/control unit must import the same codes from alu_pkg.
- One sub-module, alu_datapath, is natural. It is purely combinational: A, B, ALUControl in; result and zero out.
- The top level alu instantiates alu_datapath and adds the output register with reset and valid handling.

## Test plan
- ADD/SUB: A=10, B=20, op 000, in_valid=1.
  - Next cycle: Result=32'h0000001E, Zero=0, out_valid=1.
  - Then A=15, B=15, op 001: Result=0, Zero=1.
- Logic: A=32'hFFFF0000, B=32'h0000FFFF.
  - op 010 gives Result=0, Zero=1.
  - op 011 gives Result=32'hFFFFFFFF, Zero=0.
  - op 100 gives Result=32'hFFFFFFFF.
- SLT signed:
  - A=10, B=20 gives 1.
  - A=32'hFFFFFFFF, B=1 gives 1.
  - A=1, B=32'hFFFFFFFF gives 0.
  - A=32'h80000000, B=32'h7FFFFFFF gives 1.
- Shifts:
  - A=32'h00000001, B=32'h00000024 (amount 4), op 110 gives 32'h00000010.
  - A=32'h80000000, B=31, op 111 gives 32'h00000001.
  - A=32'hF0000000, B=32'hFFFFFFE0 (amount 0), op 111 gives 32'hF0000000.
- Valid and hold:
  - Issue ADD 1+1 with in_valid=1, then two cycles with in_valid=0 and different operands.
  - Required: Result stays 2, Zero stays 0, out_valid pattern is 1,0,0.
- Reset:
  - With Result=32'h1E, hold rst_n=0 for one edge while in_valid=1 and an ADD 5+5 is applied.
  - Required after that edge: Result=0, Zero=1, out_valid=0.
  - The next edge with rst_n=1 and ADD 5+5 gives Result=10, out_valid=1.
